// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: E-stage forwarding, load-use and branch
// handling, and multi-cycle M-stage memory waits with a timeout. HAZARD_PERF_EN adds perf counters.
module hazard_ctrl #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic [1:0] ResultSrcE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] PerfLwStall,
  output logic [31:0] PerfMemStall,
  output logic [31:0] PerfFlush
`endif
);

  typedef enum logic {ST_IDLE, ST_MEM_WAIT} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_mem_err;
  logic             w_err_set;
  logic             w_mem_stall;
  logic             w_lw_raw;
  logic             w_lw_eff;
  logic             w_branch_eff;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_err_set)
        r_mem_err <= 1'b1;
    end
  end

  // Ready is checked before the timeout so a late ready still completes cleanly.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_mem_stall  = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          w_mem_stall  = 1'b1;
          w_next_state = ST_MEM_WAIT;
          w_cnt_next   = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (MemReadyM) begin
          w_next_state = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_W'(WAIT_LIMIT)) begin
          w_err_set    = 1'b1;
          w_next_state = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_mem_stall = 1'b1;
          w_cnt_next  = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_lw_raw     = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_branch_eff = PCSrcE && !w_mem_stall;
  assign w_lw_eff     = w_lw_raw && !PCSrcE && !w_mem_stall;

  // Reset gates the outputs directly so stalls drop without waiting for a clock.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (w_mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = w_lw_eff;
        StallD = w_lw_eff;
        FlushD = w_branch_eff;
        FlushE = w_branch_eff || w_lw_eff;
      end
    end
  end

  assign MemErr = r_mem_err;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_lw;
  logic [31:0] r_perf_mem;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_lw    <= '0;
      r_perf_mem   <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_lw_eff)
        r_perf_lw <= r_perf_lw + 32'd1;
      if (w_mem_stall)
        r_perf_mem <= r_perf_mem + 32'd1;
      if (w_branch_eff)
        r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign PerfLwStall  = r_perf_lw;
  assign PerfMemStall = r_perf_mem;
  assign PerfFlush    = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then randomized traffic
// against a cycle-level behavioural model of the hazard and memory-wait rules.
module tb_hazard_ctrl;
  localparam int WL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfLwStall, PerfMemStall, PerfFlush;
  int unsigned m_pl, m_pm, m_pf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // model: cycles already stalled for the access in progress (0 = none), sticky error
  int m_stalled = 0;
  bit m_err     = 1'b0;

  hazard_ctrl #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr)
`ifdef HAZARD_PERF_EN
    , .PerfLwStall(PerfLwStall), .PerfMemStall(PerfMemStall), .PerfFlush(PerfFlush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Called at posedge+1 with inputs applied; checks mid-cycle, then advances one clock.
  task automatic run_cycle(input string tag);
    logic [6:0] got, exp;
    bit ms, lw, nerr;
    int nxt;
    #3;
    if (reset) begin
      m_stalled = 0;
      m_err     = 1'b0;
`ifdef HAZARD_PERF_EN
      m_pl = 0; m_pm = 0; m_pf = 0;
`endif
    end
    lw = (ResultSrcE == 2'b01) && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D));
    if (reset)               ms = 1'b0;
    else if (m_stalled == 0) ms = MemReqM && !MemReadyM;
    else                     ms = !MemReadyM && (m_stalled < WL);
    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    if (reset)       exp = 7'b0000000;
    else if (ms)     exp = 7'b1111001;
    else if (PCSrcE) exp = 7'b0000110;
    else if (lw)     exp = 7'b1100010;
    else             exp = 7'b0000000;
    got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    chk({tag, "_ctl"}, 32'(got), 32'(exp));
    chk({tag, "_fwdA"}, 32'(ForwardAE), reset ? 32'd0 : 32'(exp_fwd(Rs1E)));
    chk({tag, "_fwdB"}, 32'(ForwardBE), reset ? 32'd0 : 32'(exp_fwd(Rs2E)));
    chk({tag, "_err"}, 32'(MemErr), 32'(m_err));
    nxt  = m_stalled;
    nerr = m_err;
    if (!reset) begin
      if (m_stalled == 0)       nxt = ms ? 1 : 0;
      else if (MemReadyM)       nxt = 0;
      else if (m_stalled == WL) begin nxt = 0; nerr = 1'b1; end
      else                      nxt = m_stalled + 1;
`ifdef HAZARD_PERF_EN
      if (lw && !PCSrcE && !ms) m_pl++;
      if (ms) m_pm++;
      if (PCSrcE && !ms) m_pf++;
`endif
    end
    @(posedge clk);
    #1;
    m_stalled = nxt;
    m_err     = nerr;
  endtask

  task automatic quiet();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    Rs1E = 5; RdM = 5; RegWriteM = 1; MemReqM = 1;
    #1;
    run_cycle("rst");
    reset = 1'b0;
    quiet();
    run_cycle("idle");

    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
    #2; chk("fwdA_M", 32'(ForwardAE), 32'd2); chk("fwdB_0", 32'(ForwardBE), 32'd0);
    run_cycle("fwdM");
    RegWriteM = 0;
    #2; chk("fwdA_W", 32'(ForwardAE), 32'd1);
    run_cycle("fwdW");

    quiet();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #2; chk("lw_stallF", 32'(StallF), 32'd1); chk("lw_flushE", 32'(FlushE), 32'd1);
    run_cycle("lw");
    ResultSrcE = 2'b00;
    run_cycle("lw_done");
    ResultSrcE = 2'b01; RdE = 0; Rs2D = 0;
    run_cycle("lw_x0");

    ResultSrcE = 2'b01; RdE = 9; Rs1D = 9; PCSrcE = 1;
    #2; chk("br_stallF", 32'(StallF), 32'd0); chk("br_flushD", 32'(FlushD), 32'd1);
    run_cycle("br_lw");

    quiet();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) run_cycle("mw");
    MemReadyM = 1;
    #2; chk("mw_rdy_stall", 32'(StallM), 32'd0); chk("mw_rdy_flushD", 32'(FlushD), 32'd1);
    run_cycle("mw_rdy");
    MemReqM = 0; MemReadyM = 0; PCSrcE = 0;
    run_cycle("mw_after");

    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < WL; i++) run_cycle("to");
    #2; chk("to_release", 32'(StallF), 32'd0);
    run_cycle("to_end");
    MemReqM = 0;
    chk("to_err", 32'(MemErr), 32'd1);
    run_cycle("to_sticky");
    run_cycle("to_sticky2");

    MemReqM = 1; MemReadyM = 0;
    run_cycle("rw1");
    run_cycle("rw2");
    #2; reset = 1'b1;
    #1; chk("rst_async_stall", 32'(StallM), 32'd0); chk("rst_async_err", 32'(MemErr), 32'd0);
    run_cycle("rst_mid");
    reset = 1'b0;
    MemReadyM = 1;
    run_cycle("single");
    quiet();

    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemReqM    = ($urandom_range(0, 2) != 0);
      MemReadyM  = ($urandom_range(0, 3) == 0);
      run_cycle("rnd");
    end
    reset = 1'b0;
    quiet();
    run_cycle("final");

`ifdef HAZARD_PERF_EN
    chk("perf_lw", PerfLwStall, m_pl);
    chk("perf_mem", PerfMemStall, m_pm);
    chk("perf_flush", PerfFlush, m_pf);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core (F/D/E/M/W).
- Generates forwarding selects for the E-stage ALU operands.
- Generates stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers.
- Sequences multi-cycle data-memory accesses in M through a ready handshake, with a timeout watchdog.

Parameters:
- WAIT_LIMIT, 16: maximum cycles spent in MEM_WAIT before abort; legal range 2..255.
- CNT_W, 8: width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Rs1D  in  5  rs1 of instruction in D.
- Rs2D  in  5  rs2 of instruction in D.
- Rs1E  in  5  rs1 of instruction in E.
- Rs2E  in  5  rs2 of instruction in E.
- RdE  in  5  rd of instruction in E.
- RdM  in  5  rd of instruction in M.
- RdW  in  5  rd of instruction in W.
- ResultSrcE  in  2  result select in E; 2'b01 marks a load.
- RegWriteM  in  1  M instruction writes the register file.
- RegWriteW  in  1  W instruction writes the register file.
- PCSrcE  in  1  taken branch/jump resolved in E.
- MemReqM  in  1  load or store active in M.
- MemReadyM  in  1  data memory completes the access this cycle.
- ForwardAE  out  2  ALU operand A select: 00 register file, 01 W result, 10 M ALU result.
- ForwardBE  out  2  same encoding, operand B.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- StallE  out  1  hold D/E register.
- StallM  out  1  hold E/M register.
- FlushD  out  1  clear F/D register.
- FlushE  out  1  clear D/E register.
- FlushW  out  1  clear M/W register (insert bubble).
- MemErr  out  1  sticky; a memory access timed out.

Behaviour:
- Reset: asynchronous and active-high.
  - While reset is high: state=IDLE, wait counter=0, MemErr=0.
  - All Stall* and Flush* outputs are 0; ForwardAE/BE are 00.
- Forwarding is combinational, with no latency. Operand A:
  - 10 if RegWriteM, RdM!=0 and RdM==Rs1E.
  - Else 01 if RegWriteW, RdW!=0 and RdW==Rs1E.
  - Else 00.
  - M has priority over W. Operand B is identical, using Rs2E.
- Load-use hazard: lwStall = (ResultSrcE==2'b01) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- Branch: PCSrcE gives FlushD=1 and FlushE=1. PCSrcE masks lwStall, so StallF=StallD=0 that cycle; the branch wins.
- lwStall without branch: StallF=1, StallD=1, FlushE=1, for exactly one cycle per hazard.
- FSM states: IDLE and MEM_WAIT. memStall is asserted in:
  - IDLE when MemReqM=1 and MemReadyM=0.
  - MEM_WAIT when MemReadyM=0.
- memStall outputs: StallF=StallD=StallE=StallM=1 and FlushW=1; FlushD=FlushE=0.
  - memStall overrides lwStall and PCSrcE, which are both masked.
  - The branch stays held in E and takes effect on the first non-stalled cycle.
- FSM transitions:
  - IDLE -> MEM_WAIT when MemReqM=1 and MemReadyM=0; counter loads 1.
  - MEM_WAIT: if MemReadyM=1, memStall=0 that cycle and next state is IDLE. This gives zero extra latency after ready.
  - MEM_WAIT: else the counter increments. When counter==WAIT_LIMIT, memStall=0 that cycle, MemErr is set (sticky until reset), next state is IDLE and the counter clears.
  - IDLE with MemReqM=1 and MemReadyM=1 is a single-cycle access: no stall, no state change.
- Back-to-back accesses: after returning to IDLE, a new MemReqM in M with MemReadyM=0 stalls again immediately.
- Forwarding outputs are unaffected by stall state.
- Reset asserted mid-MEM_WAIT: the FSM goes to IDLE immediately, all stalls drop asynchronously and the counter clears.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds three 32-bit outputs.
  - PerfLwStall: counts cycles with an effective (unmasked) lwStall.
  - PerfMemStall: counts cycles with memStall=1.
  - PerfFlush: counts cycles with PCSrcE effective, i.e. not masked by memStall.
  - All three are reset to 0, wrap modulo 2^32 and update on the rising edge.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01.
- ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for one cycle. Same with RdE=0 -> no stall.
- lwStall condition plus PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
- MemReqM=1, MemReadyM low for 3 cycles then high -> Stall{F,D,E,M}=FlushW=1 for 3 cycles, 0 on the ready cycle, FSM returns to IDLE, MemErr=0.
- WAIT_LIMIT=4, MemReqM=1, MemReadyM held 0 -> stall for 4 cycles, released on the cycle the counter hits 4, MemErr=1 and stays 1 until reset.
- Reset pulsed during MEM_WAIT -> all stalls 0 and MemErr 0 immediately. After release, MemReqM=1 with MemReadyM=1 -> no stall.
